bluetooth_decoder: RTL and testbench
====================================

// Module: bluetooth_decoder
// PURPOSE
//   Receive-side counterpart of bluetooth_encoder. Parses the ASCII reply stream from the BLE module
//   (byte-wide, from the UART receiver) after an AT+BLEUARTRX command has been issued.
//   Extracts up to 4 payload bytes and the final status line ("OK" / "ERROR").
//   Presents the payload in the same byte order the encoder uses: first byte in [7:0].
// PARAMETERS
//   TIMEOUT_CYCLES  1000000  idle cycles allowed between received bytes while busy; counter width $clog2(TIMEOUT_CYCLES)
// PORTS
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   start        in   1   arm decoder for one reply; sampled only in IDLE
//   rx_data      in   8   received ASCII byte
//   rx_valid     in   1   rx_data valid this cycle (single-cycle strobe per byte)
//   output_data  out  32  payload; byte k at [8k+7:8k]; unused bytes 0
//   byte_count   out  3   payload length 0..4
//   error_code   out  2   0=OK, 1=module ERROR, 2=framing/protocol, 3=timeout
//   data_valid   out  1   one-cycle pulse: reply complete, outputs valid
//   done         out  1   high when idle (matches encoder), low while a reply is being parsed
// BEHAVIOUR
//   One clock; reset is synchronous and active-high; all state updates on posedge clk.
//   Reset values: output_data=0, byte_count=0, error_code=0, data_valid=0, done=1.
//     Internally: state=IDLE, line_buf=0, line_len=0, line_ovf=0, payload_seen=0, timer=0.
//     Reset mid-reply aborts it; no data_valid is produced.
//   States: IDLE -> LINE <-> EXPECT_LF -> (finish) IDLE.
//   IDLE: rx_valid is ignored. On start=1:
//     clear output_data, byte_count, error_code, line state and payload_seen;
//     set done<=0; go to LINE.
//   LINE, on rx_valid:
//     byte==0x0D -> EXPECT_LF.
//     else if line_len<5 -> line_buf[8*line_len+:8]<=byte; line_len++.
//     else (6th+ byte) -> line_ovf<=1; byte dropped; stay in LINE.
//   EXPECT_LF, on rx_valid:
//     byte!=0x0A -> finish, code 2.
//     byte==0x0A -> classify the line, then clear line_buf, line_len and line_ovf:
//       line_len==2 and buf=="OK" ('O'=0x4F, 'K'=0x4B)    -> finish, code 0.
//       line_len==5 and buf=="ERROR"                        -> finish, code 1.
//       line_len==0 (blank line)                            -> back to LINE.
//       !payload_seen, !line_ovf, line_len<=4               -> output_data<=line_buf[31:0], byte_count<=line_len, payload_seen<=1, back to LINE.
//       otherwise (overflow, or a second payload line)      -> finish, code 2.
//   A 5-byte payload reading "ERROR" is indistinguishable from a status line and is treated as code 1.
//   Finish: error_code set; data_valid=1 for exactly one cycle; done<=1; state<=IDLE.
//     Latency: data_valid is asserted in the cycle after the terminating byte is accepted.
//     On any error, output_data/byte_count keep whatever payload was latched (0 if none).
//   Timeout: timer counts cycles in LINE/EXPECT_LF with rx_valid=0; cleared on every rx_valid and on start.
//     On reaching TIMEOUT_CYCLES-1 -> finish, code 3.
//     rx_valid in the same cycle as the timeout cycle wins; the timer clears.
//   start while done=0 is ignored. start in the same cycle as the data_valid pulse is ignored (state not yet IDLE).
//   Outputs are held stable between data_valid pulses until the next accepted start.
// TESTING
//   1. start; "AB\r\n\r\nOK\r\n" -> one data_valid pulse, output_data=32'h0000_4241, byte_count=2, error_code=0, done=1.
//   2. start; "OK\r\n" -> output_data=0, byte_count=0, error_code=0; "WXYZ\r\nOK\r\n" -> 32'h5A59_5857, count=4.
//   3. start; "ERROR\r\n" -> error_code=1. start; "ABCDEF\r\n" -> code 2. start; "AB\rX" -> code 2 on 'X'.
//   4. TIMEOUT_CYCLES=16; start, no bytes -> data_valid 16 cycles after the start cycle, error_code=3.
//      Repeat with a byte every 10 cycles -> no timeout.
//   5. Bytes with rx_valid in IDLE -> no state change. start pulsed mid-reply -> ignored.
//      reset asserted after "AB" -> reset values next cycle; no data_valid.
//   6. Two payload lines "A\r\nB\r\nOK\r\n" -> code 2, output_data=32'h41, byte_count=1.

Source files
------------

// File: rtl/bluetooth_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bluetooth_decoder
//  Description : Parses the BLE module's ASCII reply to AT+BLEUARTRX into an
//                up-to-4-byte payload (first byte in [7:0]) and a status code.
//  Revision    : 1.0  initial release
// ============================================================================
module bluetooth_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] output_data,
    output logic [2:0]  byte_count,
    output logic [1:0]  error_code,
    output logic        data_valid,
    output logic        done
);

    localparam int c_TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Comparing against LIMIT-2 makes the finish land as the timer reaches LIMIT-1
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_LINE      = 2'd1;
    localparam logic [1:0] c_ST_EXPECT_LF = 2'd2;
    localparam logic [1:0] c_ST_FINISH    = 2'd3;

    localparam logic [1:0] c_CODE_OK      = 2'd0;
    localparam logic [1:0] c_CODE_MODERR  = 2'd1;
    localparam logic [1:0] c_CODE_FRAMING = 2'd2;
    localparam logic [1:0] c_CODE_TIMEOUT = 2'd3;

    localparam logic [7:0]  c_CR       = 8'h0D;
    localparam logic [7:0]  c_LF       = 8'h0A;
    localparam logic [15:0] c_STR_OK   = 16'h4B4F;
    localparam logic [39:0] c_STR_ERR  = 40'h52_4F_52_52_45;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [31:0]     r_output_data;
    logic [2:0]      r_byte_count;
    logic [1:0]      r_error_code;
    logic [39:0]     r_line_buf;
    logic [2:0]      r_line_len;
    logic            r_line_ovf;
    logic            r_payload_seen;
    logic [c_TW-1:0] r_timer;

    logic            w_finish;
    logic [1:0]      w_code;
    logic            w_take_payload;
    logic            w_timeout;
    logic            w_is_ok;
    logic            w_is_err;

    assign w_is_ok   = (r_line_len == 3'd2) && (r_line_buf[15:0] == c_STR_OK);
    assign w_is_err  = (r_line_len == 3'd5) && (r_line_buf == c_STR_ERR);
    assign w_timeout = !rx_valid && (r_timer == c_TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_finish       = 1'b0;
        w_code         = c_CODE_OK;
        w_take_payload = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_LINE;
                end
            end
            c_ST_LINE: begin
                if (rx_valid) begin
                    if (rx_data == c_CR) begin
                        w_state_next = c_ST_EXPECT_LF;
                    end
                end else if (w_timeout) begin
                    w_finish = 1'b1;
                    w_code   = c_CODE_TIMEOUT;
                end
            end
            c_ST_EXPECT_LF: begin
                if (rx_valid) begin
                    if (rx_data != c_LF) begin
                        w_finish = 1'b1;
                        w_code   = c_CODE_FRAMING;
                    end else if (w_is_ok) begin
                        w_finish = 1'b1;
                        w_code   = c_CODE_OK;
                    end else if (w_is_err) begin
                        w_finish = 1'b1;
                        w_code   = c_CODE_MODERR;
                    end else if (r_line_len == 3'd0) begin
                        w_state_next = c_ST_LINE;
                    end else if (!r_payload_seen && !r_line_ovf && (r_line_len <= 3'd4)) begin
                        w_state_next   = c_ST_LINE;
                        w_take_payload = 1'b1;
                    end else begin
                        w_finish = 1'b1;
                        w_code   = c_CODE_FRAMING;
                    end
                end else if (w_timeout) begin
                    w_finish = 1'b1;
                    w_code   = c_CODE_TIMEOUT;
                end
            end
            c_ST_FINISH: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
        if (w_finish) begin
            w_state_next = c_ST_FINISH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_output_data  <= '0;
            r_byte_count   <= '0;
            r_error_code   <= '0;
            r_line_buf     <= '0;
            r_line_len     <= '0;
            r_line_ovf     <= 1'b0;
            r_payload_seen <= 1'b0;
            r_timer        <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_output_data  <= '0;
                        r_byte_count   <= '0;
                        r_error_code   <= '0;
                        r_line_buf     <= '0;
                        r_line_len     <= '0;
                        r_line_ovf     <= 1'b0;
                        r_payload_seen <= 1'b0;
                        r_timer        <= '0;
                    end
                end
                c_ST_LINE, c_ST_EXPECT_LF: begin
                    r_timer <= rx_valid ? '0 : r_timer + 1'b1;
                    if (w_finish) begin
                        r_error_code <= w_code;
                    end
                    if (rx_valid && (r_state == c_ST_LINE) && (rx_data != c_CR)) begin
                        if (r_line_len < 3'd5) begin
                            r_line_buf[{r_line_len, 3'b000} +: 8] <= rx_data;
                            r_line_len <= r_line_len + 3'd1;
                        end else begin
                            r_line_ovf <= 1'b1;
                        end
                    end
                    if (rx_valid && (r_state == c_ST_EXPECT_LF) && (rx_data == c_LF)) begin
                        r_line_buf <= '0;
                        r_line_len <= '0;
                        r_line_ovf <= 1'b0;
                        if (w_take_payload) begin
                            r_output_data  <= r_line_buf[31:0];
                            r_byte_count   <= r_line_len;
                            r_payload_seen <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FINISH is a one-cycle state so a start arriving with the pulse is ignored
    always_comb begin
        output_data = r_output_data;
        byte_count  = r_byte_count;
        error_code  = r_error_code;
        data_valid  = (r_state == c_ST_FINISH);
        done        = (r_state == c_ST_IDLE) || (r_state == c_ST_FINISH);
    end

endmodule
`default_nettype wire

// File: tb/tb_bluetooth_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bluetooth_decoder
//  Description : Scoreboard bench for bluetooth_decoder with directed replies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bluetooth_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] output_data;
    logic [2:0]  byte_count;
    logic [1:0]  error_code;
    logic        data_valid;
    logic        done;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  count;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   dv_count = 0;
    int   exp_dv = 0;
    int   cyc = 0;
    int   last_dv_cyc = 0;
    int   start_cyc = 0;
    int   saved;

    bluetooth_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .output_data (output_data),
        .byte_count  (byte_count),
        .error_code  (error_code),
        .data_valid  (data_valid),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every data_valid pulse
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            exp_t e;
            dv_count++;
            last_dv_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_dv: data_valid with empty scoreboard, data %h code %0d",
                         output_data, error_code);
            end else begin
                e = exp_q.pop_front();
                check("dv_data", output_data, e.data);
                check("dv_count", 32'(byte_count), 32'(e.count));
                check("dv_code", 32'(error_code), 32'(e.code));
                check("dv_done", 32'(done), 32'd1);
            end
        end
    end

    task automatic expect_reply(input logic [31:0] d, input logic [2:0] c, input logic [1:0] e);
        exp_t x;
        x.data = d;
        x.count = c;
        x.code = e;
        exp_q.push_back(x);
        exp_dv++;
    endtask

    task automatic pulse_start();
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], gap);
        end
    endtask

    task automatic send_line(input string s, input int gap);
        send_str(s, gap);
        send_byte(8'h0D, gap);
        send_byte(8'h0A, gap);
    endtask

    task automatic wait_dv(input int target, input string name);
        int budget;
        budget = 200;
        while (dv_count < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        n_vec++;
        if (dv_count < target) begin
            n_err++;
            $display("FAIL %s: data_valid count %0d, required %0d", name, dv_count, target);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_done", 32'(done), 32'd1);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_data", output_data, 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        check("rst_code", 32'(error_code), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Payload, blank line, OK; start offered during the data_valid pulse
        expect_reply(32'h0000_4241, 3'd2, 2'd0);
        pulse_start();
        send_line("AB", 1);
        send_line("", 1);
        send_str("OK", 1);
        send_byte(8'h0D, 1);
        send_byte(8'h0A, 0);
        pulse_start();
        wait_dv(exp_dv, "t1_wait");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("start_in_pulse_ignored", 32'(done), 32'd1);
        @(posedge clk); #1;

        expect_reply(32'h0, 3'd0, 2'd0);
        pulse_start();
        send_line("OK", 1);
        wait_dv(exp_dv, "t2a_wait");

        expect_reply(32'h5A59_5857, 3'd4, 2'd0);
        pulse_start();
        send_line("WXYZ", 1);
        send_line("OK", 1);
        wait_dv(exp_dv, "t2b_wait");

        expect_reply(32'h0, 3'd0, 2'd1);
        pulse_start();
        send_line("ERROR", 1);
        wait_dv(exp_dv, "t3a_wait");

        expect_reply(32'h0, 3'd0, 2'd2);
        pulse_start();
        send_line("ABCDEF", 1);
        wait_dv(exp_dv, "t3b_wait");

        expect_reply(32'h0, 3'd0, 2'd2);
        pulse_start();
        send_str("AB", 1);
        send_byte(8'h0D, 1);
        send_byte(8'h58, 1);
        wait_dv(exp_dv, "t3c_wait");

        // Timeout with no bytes
        expect_reply(32'h0, 3'd0, 2'd3);
        pulse_start();
        wait_dv(exp_dv, "t4a_wait");
        check("timeout_latency", 32'(last_dv_cyc - start_cyc), 32'd16);

        // Slow but steady stream never times out
        expect_reply(32'h0000_4241, 3'd2, 2'd0);
        pulse_start();
        send_line("AB", 9);
        send_line("OK", 9);
        wait_dv(exp_dv, "t4b_wait");

        // Bytes in IDLE are ignored and outputs hold
        saved = dv_count;
        send_line("OK", 1);
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_dv", 32'(dv_count), 32'(saved));
        check("idle_done", 32'(done), 32'd1);
        check("idle_data_held", output_data, 32'h0000_4241);
        check("idle_count_held", 32'(byte_count), 32'd2);

        // start mid-reply must not restart the line
        expect_reply(32'h0000_4241, 3'd2, 2'd0);
        pulse_start();
        send_str("A", 1);
        pulse_start();
        send_line("B", 1);
        send_line("OK", 1);
        wait_dv(exp_dv, "t5b_wait");

        // Reset mid-reply aborts with no pulse
        saved = dv_count;
        pulse_start();
        send_str("AB", 1);
        @(negedge clk);
        check("busy_before_reset", 32'(done), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_done", 32'(done), 32'd1);
        check("mid_rst_dv", 32'(data_valid), 32'd0);
        check("mid_rst_data", output_data, 32'd0);
        check("mid_rst_count", 32'(byte_count), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("mid_rst_no_dv", 32'(dv_count), 32'(saved));

        expect_reply(32'h0000_005A, 3'd1, 2'd0);
        pulse_start();
        send_line("Z", 1);
        send_line("OK", 1);
        wait_dv(exp_dv, "t5c_wait");

        // Second payload line is a protocol error; first payload kept
        expect_reply(32'h0000_0041, 3'd1, 2'd2);
        pulse_start();
        send_line("A", 1);
        send_line("B", 1);
        wait_dv(exp_dv, "t6_wait");

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("final_dv_total", 32'(dv_count), 32'(exp_dv));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
